fetch_buffer_unit: RTL and testbench
====================================

Name: fetch_buffer_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Generates sequential instruction addresses and issues single-outstanding 32-bit reads to instruction memory.
- Buffers returned words with their PC in a small FIFO and presents them to decode as `instruction_t` (opcode in bits [6:0]) through a valid/ready handshake.
- Accepts redirects (branch/jump/trap) that flush the buffer and discard any in-flight response.

Parameters:
- ADDR_WIDTH, 64, width of PCs and memory addresses.
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 0, fetch address after reset.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] forced to 0.
- mem_rd_en  output  1  read request, held until mem_ack.
- mem_addr  output  ADDR_WIDTH  read address, stable while mem_rd_en is high.
- mem_ack  input  1  read data valid this cycle; only meaningful while mem_rd_en is high.
- mem_rd_data  input  32  instruction word.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decoder accepts the head.
- instruction  output  32  head instruction, `instruction_t` layout.
- inst_pc  output  ADDR_WIDTH  PC of the head instruction.

Behaviour:
- Reset (async assert): pc=RESET_PC, FIFO empty (count=0, pointers 0), state=Idle, mem_rd_en=0, inst_valid=0. instruction and inst_pc are don't-care while inst_valid=0.
- FSM states and outputs:
  - Idle, Request, Drop.
  - mem_rd_en = (state != Idle).
  - mem_addr = pc in Request; in Drop it holds the address of the abandoned request.
- Idle: if count < DEPTH and no redirect → Request next cycle. First request after reset appears 1 cycle after reset deassert.
- Request, mem_ack=1:
  - Push {pc, mem_rd_data}; pc += 4.
  - Stay in Request (back-to-back, new address next cycle) if count_next < DEPTH, else → Idle.
  - count_next = count + 1 − pop.
- Request, mem_ack=0: hold address, stay in Request.
- Drop: wait for mem_ack, discard the data, → Idle. pc is unaffected by the discarded response.
- Redirect (highest priority, any state):
  - FIFO cleared the same cycle; a simultaneous pop or push is suppressed.
  - pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - In Request: without mem_ack → Drop; with mem_ack → data discarded, → Idle.
  - In Drop: without mem_ack → stay in Drop (pc updated); with mem_ack → Idle.
  - In Idle → stays Idle (normal Idle rules apply next cycle).
- FIFO:
  - inst_valid = (count != 0). instruction and inst_pc come combinationally from the head entry.
  - Pop when inst_valid && inst_ready.
  - Push and pop in the same cycle are both allowed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible: a request is only outstanding while count < DEPTH, and pops only reduce count.
  - Pop on empty is ignored.
- Latency:
  - Ack at cycle N → inst_valid at N+1 (registered FIFO write).
  - Redirect at N → new request at N+2 if no response was in flight, else 1 cycle after the Drop ack.
- PC arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones−3 to 0 is silent.
- Memory data is stored unmodified. The block does no decoding or illegal-opcode checks.

Test Plan:
- Reset release, memory acking every cycle, inst_ready=1 → mem_addr sequence 0x0, 0x4, 0x8… one per cycle; inst_pc follows 1 cycle after each ack; inst_valid continuous.
- inst_ready=0, memory always acks, DEPTH=4:
  - Exactly 4 words (PCs 0x0–0xC) accepted, then mem_rd_en=0, count=4.
  - Raising inst_ready pops 0x0 first; fetching resumes at 0x10.
- Redirect to 0x1002 while a request to 0x8 is pending (ack 3 cycles later, data 0xDEADBEEF):
  - FIFO empties immediately; mem_addr stays 0x8 until the ack.
  - 0xDEADBEEF never appears on instruction.
  - Next request is to 0x1000.
- Redirect in the same cycle as mem_ack and a pop → acked word discarded, inst_valid=0 next cycle, next request to redirect_pc.
- Second redirect (0x200, then 0x300) while in Drop → after the Drop ack, first request is to 0x300.
- Asynchronous reset asserted mid-Request with count=3 → mem_rd_en and inst_valid drop to 0 without waiting for clock; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit: sequential instruction fetch with a small PC-tagged FIFO feeding decode
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   redirect, redirect_pc   flush the buffer and restart fetch at redirect_pc (word aligned)
//   mem_rd_en, mem_addr     single-outstanding read request, held until mem_ack
//   mem_ack, mem_rd_data    read response
//   inst_valid, inst_ready  decode handshake on the FIFO head
//   instruction, inst_pc    head word (instruction_t layout, opcode in [6:0]) and its PC
module fetch_buffer_unit #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rd_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] inst_pc
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQUEST, DROP} state_t;
  typedef struct packed {
    logic [24:0] upper;
    logic [6:0]  opcode;
  } instruction_t;
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] pc, drop_addr;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_next;
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  instruction_t inst_mem [DEPTH];
  logic push, pop;
  assign inst_valid = count != '0;
  // a redirect wipes the FIFO, so neither side of the handshake may take effect that cycle
  assign pop = inst_valid && inst_ready && !redirect;
  assign push = state == REQUEST && mem_ack && !redirect;
  assign count_next = redirect ? '0 : count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign mem_rd_en = state != IDLE;
  // pc may already point at the redirect target while the abandoned read is still open
  assign mem_addr = state == DROP ? drop_addr : pc;
  assign instruction = inst_mem[rd_ptr];
  assign inst_pc = pc_mem[rd_ptr];
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = !redirect && count < (PW+1)'(DEPTH) ? REQUEST : IDLE;
      REQUEST: state_next = redirect ? (mem_ack ? IDLE : DROP)
                          : !mem_ack || count_next < (PW+1)'(DEPTH) ? REQUEST : IDLE;
      DROP:    state_next = mem_ack ? IDLE : DROP;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      drop_addr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (redirect && state == REQUEST) drop_addr <= pc;
      if (redirect) begin
        pc <= redirect_pc & ~ADDR_WIDTH'(3);
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) pc <= pc + ADDR_WIDTH'(4);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem[wr_ptr] <= mem_rd_data;
      pc_mem[wr_ptr] <= pc;
    end
  end
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// tb_fetch_buffer_unit: directed scoreboard bench for fetch_buffer_unit
module tb_fetch_buffer_unit;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;
  logic clock = 0;
  logic reset;
  logic redirect;
  logic [63:0] redirect_pc;
  logic mem_rd_en;
  logic [63:0] mem_addr;
  logic mem_ack;
  logic [31:0] mem_rd_data;
  logic inst_valid;
  logic inst_ready;
  logic [31:0] instruction;
  logic [63:0] inst_pc;
  logic override;
  logic [31:0] ovr_data;
  int compared = 0;
  int mismatched = 0;
  ent_t exp_q[$];
  logic [63:0] exp_pc, drop_addr;
  bit dropping;

  fetch_buffer_unit #(.ADDR_WIDTH(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc)
  );

  always #5 clock = ~clock;
  assign mem_rd_data = override ? ovr_data : {mem_addr[15:0] ^ 16'hBEEF, mem_addr[15:0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    ent_t e;
    bit ack_fire;
    #1;
    ack_fire = mem_rd_en && mem_ack;
    if (inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", inst_pc, 64'hx);
      end else begin
        e = exp_q.pop_front();
        chk("pop_pc", inst_pc, e.pc);
        chk("pop_data", {32'h0, instruction}, {32'h0, e.data});
      end
    end
    if (redirect) begin
      if (dropping) begin
        if (ack_fire) dropping = 0;
      end else if (mem_rd_en) begin
        chk("redirect_addr", mem_addr, exp_pc);
        if (!mem_ack) begin
          dropping = 1;
          drop_addr = exp_pc;
        end
      end
      exp_q.delete();
      exp_pc = {redirect_pc[63:2], 2'b00};
    end else if (ack_fire) begin
      if (dropping) begin
        chk("drop_addr", mem_addr, drop_addr);
        dropping = 0;
      end else begin
        chk("req_addr", mem_addr, exp_pc);
        exp_q.push_back({exp_pc, mem_rd_data});
        exp_pc = exp_pc + 64'd4;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    redirect = 0;
    redirect_pc = '0;
    mem_ack = 0;
    inst_ready = 0;
    override = 0;
    exp_q.delete();
    exp_pc = 64'h0;
    dropping = 0;
    @(posedge clock);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 0;
    redirect = 0;
    redirect_pc = '0;
    mem_ack = 0;
    inst_ready = 0;
    override = 0;
    ovr_data = 32'hDEADBEEF;
    dropping = 0;
    exp_pc = 0;
    #1 reset = 1;
    #1;
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_valid", inst_valid, 0);
    do_reset();
    // streaming: one sequential read per cycle, decode always ready
    inst_ready = 1;
    mem_ack = 1;
    chk("post_reset_idle", mem_rd_en, 0);
    tick();
    chk("first_req_en", mem_rd_en, 1);
    chk("first_req_addr", mem_addr, 64'h0);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("stream_valid", inst_valid, 1);
      chk("stream_addr", mem_addr, exp_pc);
      chk("stream_pc", inst_pc, exp_pc - 64'd4);
      tick();
    end
    // backpressure: FIFO fills to DEPTH and fetch stops
    do_reset();
    mem_ack = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("full_rd_en", mem_rd_en, 0);
    chk("full_valid", inst_valid, 1);
    chk("full_head_pc", inst_pc, 64'h0);
    tick();
    tick();
    chk("full_hold_rd_en", mem_rd_en, 0);
    chk("full_hold_head", inst_pc, 64'h0);
    inst_ready = 1;
    begin
      int n = 0;
      while (!mem_rd_en && n < 6) begin
        tick();
        n++;
      end
      chk("resume_wait_rd_en", mem_rd_en, 1);
    end
    chk("resume_addr", mem_addr, 64'h10);
    for (int i = 0; i < 4; i++) tick();
    // redirect with an outstanding read to 0x8 acked three cycles later
    do_reset();
    mem_ack = 1;
    tick();
    tick();
    tick();
    mem_ack = 0;
    chk("pre_redirect_addr", mem_addr, 64'h8);
    chk("pre_redirect_valid", inst_valid, 1);
    redirect = 1;
    redirect_pc = 64'h1002;
    tick();
    redirect = 0;
    chk("flush_valid", inst_valid, 0);
    chk("drop_rd_en", mem_rd_en, 1);
    chk("drop_hold_addr", mem_addr, 64'h8);
    tick();
    chk("drop_hold_addr2", mem_addr, 64'h8);
    tick();
    override = 1;
    mem_ack = 1;
    tick();
    override = 0;
    chk("after_drop_idle", mem_rd_en, 0);
    chk("after_drop_valid", inst_valid, 0);
    tick();
    chk("redirect_target", mem_addr, 64'h1000);
    inst_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (inst_valid) chk("no_dropped_word", {32'h0, instruction == 32'hDEADBEEF}, 64'h0);
      tick();
    end
    // redirect coinciding with an ack and a pop
    do_reset();
    mem_ack = 1;
    inst_ready = 1;
    tick();
    tick();
    chk("coincide_valid", inst_valid, 1);
    redirect = 1;
    redirect_pc = 64'h40;
    tick();
    redirect = 0;
    chk("coincide_flush", inst_valid, 0);
    chk("coincide_idle", mem_rd_en, 0);
    tick();
    chk("coincide_target", mem_addr, 64'h40);
    tick();
    chk("coincide_head_pc", inst_pc, 64'h40);
    tick();
    // second redirect while dropping
    do_reset();
    mem_ack = 1;
    tick();
    tick();
    mem_ack = 0;
    redirect = 1;
    redirect_pc = 64'h200;
    tick();
    redirect_pc = 64'h300;
    tick();
    redirect = 0;
    chk("double_drop_addr", mem_addr, 64'h4);
    mem_ack = 1;
    tick();
    chk("double_idle", mem_rd_en, 0);
    tick();
    chk("double_target", mem_addr, 64'h300);
    tick();
    // PC wraps silently past the top of the address space
    do_reset();
    redirect = 1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 0;
    mem_ack = 1;
    inst_ready = 1;
    tick();
    chk("wrap_top_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_zero_addr", mem_addr, 64'h0);
    tick();
    tick();
    // asynchronous reset in the middle of a request with three buffered words
    do_reset();
    mem_ack = 1;
    tick();
    tick();
    tick();
    tick();
    mem_ack = 0;
    chk("mid_rd_en", mem_rd_en, 1);
    chk("mid_valid", inst_valid, 1);
    chk("mid_addr", mem_addr, 64'hC);
    #2 reset = 1;
    #1;
    chk("async_rd_en", mem_rd_en, 0);
    chk("async_valid", inst_valid, 0);
    exp_q.delete();
    exp_pc = 64'h0;
    dropping = 0;
    @(posedge clock);
    #1;
    reset = 0;
    mem_ack = 1;
    inst_ready = 1;
    chk("async_release_idle", mem_rd_en, 0);
    tick();
    chk("async_restart_addr", mem_addr, 64'h0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
